// File: rtl/proc_pkg.sv
// Shared definitions for the 3-stage processor: default widths, opcode nibbles
// and the execute-stage state encoding.
`default_nettype none

package proc_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_IMM_W  = 4;

  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_IN   = 4'h4;
  localparam logic [3:0] OP_OUT  = 4'h5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_IN  = 2'd1,
    WAIT_OUT = 2'd2
  } exec_state_t;

endpackage

`default_nettype wire

// File: rtl/exec_alu.sv
// exec_alu: combinational accumulator datapath for load/add/sub/bitand.
// Rev 1.0
`default_nettype none

module exec_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IMM_W  = DEFAULT_IMM_W
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [IMM_W-1:0]  imm,
  input  logic              load,
  input  logic              add,
  input  logic              sub,
  input  logic              bitand,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W-1:0] imm_x;
  logic [DATA_W:0]   sum;

  assign imm_x = {{(DATA_W-IMM_W){1'b0}}, imm};
  assign sum   = {1'b0, acc} + {1'b0, imm_x};

  // Strobes are assumed one-hot here; the stage suppresses the write otherwise.
  always_comb begin
    result = acc;
    carry  = 1'b0;
    if (load) begin
      result = imm_x;
    end else if (add) begin
      result = sum[DATA_W-1:0];
      carry  = sum[DATA_W];
    end else if (sub) begin
      result = acc - imm_x;
      carry  = (acc < imm_x);
    end else if (bitand) begin
      result = acc & imm_x;
    end
  end

  assign zero = (result == '0);

endmodule

`default_nettype wire

// File: rtl/exec_stage.sv
// exec_stage: execute stage owning the accumulator, Z/C flags, I/O port
// handshakes and the retired-instruction counter.  Rev 1.0
`default_nettype none

module exec_stage
  import proc_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IMM_W  = DEFAULT_IMM_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              load,
  input  logic              add,
  input  logic              sub,
  input  logic              bitand,
  input  logic              inp,
  input  logic              out,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] acc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  exec_state_t       state;
  logic              accept;
  logic              legal;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  assign instr_ready = (state == RUN);
  assign in_ready    = (state == WAIT_IN);
  assign accept      = instr_valid & instr_ready;
  assign legal       = $onehot({load, add, sub, bitand, inp, out});

  exec_alu #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_alu (
    .acc    (acc),
    .imm    (imm),
    .load   (load),
    .add    (add),
    .sub    (sub),
    .bitand (bitand),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      acc       <= '0;
      flag_z    <= 1'b1;
      flag_c    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      retired   <= '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            if (!legal) begin
              illegal <= 1'b1;
            end else if (inp) begin
              state <= WAIT_IN;
            end else if (out) begin
              out_data  <= acc;
              out_valid <= 1'b1;
              state     <= WAIT_OUT;
            end else begin
              acc     <= alu_result;
              flag_c  <= alu_carry;
              flag_z  <= alu_zero;
              retired <= retired + CNT_W'(1);
            end
          end
        end
        WAIT_IN: begin
          if (in_valid) begin
            acc     <= in_data;
            flag_z  <= (in_data == '0);
            retired <= retired + CNT_W'(1);
            state   <= RUN;
          end
        end
        WAIT_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            retired   <= retired + CNT_W'(1);
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exec_stage.sv
// tb_exec_stage: table vectors, directed corner sequences and a randomized run
// against an arithmetic reference model of the execute stage.
`default_nettype none

module tb_exec_stage;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic        load, add, sub, bitand, inp, out;
  logic [3:0]  imm;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  acc;
  logic        flag_z;
  logic        flag_c;
  logic        illegal;
  logic [15:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_acc;
  bit          m_z;
  bit          m_c;
  logic [15:0] m_ret;

  always #5 clk = ~clk;

  exec_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .load        (load),
    .add         (add),
    .sub         (sub),
    .bitand      (bitand),
    .inp         (inp),
    .out         (out),
    .imm         (imm),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .acc         (acc),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .illegal     (illegal),
    .retired     (retired)
  );

  typedef struct {
    logic [3:0] op;
    logic [3:0] imm;
    int         exp_acc;
    bit         exp_c;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic set_mask(input logic [5:0] m);
    {load, add, sub, bitand, inp, out} = m;
  endtask

  task automatic set_op(input logic [3:0] op);
    case (op)
      OP_LOAD: set_mask(6'b100000);
      OP_ADD:  set_mask(6'b010000);
      OP_SUB:  set_mask(6'b001000);
      OP_AND:  set_mask(6'b000100);
      OP_IN:   set_mask(6'b000010);
      OP_OUT:  set_mask(6'b000001);
      default: set_mask(6'b000000);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 0; m_z = 1'b1; m_c = 1'b0; m_ret = 16'h0;
  endtask

  task automatic model_alu(input logic [3:0] op, input int i);
    int t;
    case (op)
      OP_LOAD: begin m_acc = i; m_c = 1'b0; end
      OP_ADD: begin t = m_acc + i; m_c = (t > 255); m_acc = t % 256; end
      OP_SUB: begin m_c = (m_acc < i); m_acc = (m_acc - i + 256) % 256; end
      default: begin m_acc = m_acc & i; m_c = 1'b0; end
    endcase
    m_z = (m_acc == 0);
    m_ret = m_ret + 16'd1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".acc"}, {24'h0, acc}, m_acc);
    check({tag, ".z"}, {31'h0, flag_z}, {31'h0, m_z});
    check({tag, ".c"}, {31'h0, flag_c}, {31'h0, m_c});
    check({tag, ".retired"}, {16'h0, retired}, {16'h0, m_ret});
  endtask

  task automatic do_alu(input logic [3:0] op, input logic [3:0] i);
    check("alu.ready", {31'h0, instr_ready}, 32'd1);
    set_op(op); imm = i; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; set_mask(6'b0);
    model_alu(op, int'(i));
    check_state("alu");
    check("alu.illegal", {31'h0, illegal}, 32'd0);
  endtask

  task automatic do_in(input logic [7:0] d, input int stall);
    check("in.ready_before", {31'h0, instr_ready}, 32'd1);
    set_op(OP_IN); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; set_mask(6'b0);
    for (int k = 0; k < stall; k++) begin
      check("in.stall_instr_ready", {31'h0, instr_ready}, 32'd0);
      check("in.stall_in_ready", {31'h0, in_ready}, 32'd1);
      tick();
    end
    check("in.in_ready", {31'h0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
    m_acc = int'(d); m_z = (d == 8'h0); m_ret = m_ret + 16'd1;
    check_state("in");
    check("in.back_to_run", {31'h0, instr_ready}, 32'd1);
  endtask

  task automatic do_out(input int stall);
    logic [7:0] exp_d;
    exp_d = m_acc[7:0];
    set_op(OP_OUT); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; set_mask(6'b0);
    for (int k = 0; k < stall; k++) begin
      check("out.valid_hold", {31'h0, out_valid}, 32'd1);
      check("out.data_hold", {24'h0, out_data}, {24'h0, exp_d});
      check("out.instr_ready", {31'h0, instr_ready}, 32'd0);
      tick();
    end
    check("out.valid", {31'h0, out_valid}, 32'd1);
    check("out.data", {24'h0, out_data}, {24'h0, exp_d});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    m_ret = m_ret + 16'd1;
    check("out.valid_drop", {31'h0, out_valid}, 32'd0);
    check_state("out");
  endtask

  task automatic do_illegal(input logic [5:0] m, input logic [3:0] i);
    set_mask(m); imm = i; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; set_mask(6'b0);
    check("illegal.pulse", {31'h0, illegal}, 32'd1);
    check_state("illegal");
    tick();
    check("illegal.clear", {31'h0, illegal}, 32'd0);
    check_state("illegal_after");
  endtask

  initial begin
    logic [5:0] mask;
    int         sel;

    vecs[0] = '{OP_LOAD, 4'hF, 8'h0F, 1'b0};
    vecs[1] = '{OP_ADD,  4'h1, 8'h10, 1'b0};
    vecs[2] = '{OP_SUB,  4'h3, 8'h0D, 1'b0};
    vecs[3] = '{OP_AND,  4'h6, 8'h04, 1'b0};

    in_data = 8'h0; in_valid = 1'b0; out_ready = 1'b0; imm = 4'h0;

    // reset held with a live add on the bus
    rst_n = 1'b0; instr_valid = 1'b1; set_op(OP_ADD); imm = 4'h7;
    repeat (2) tick();
    model_reset();
    check_state("reset");
    check("reset.out_valid", {31'h0, out_valid}, 32'd0);
    check("reset.illegal", {31'h0, illegal}, 32'd0);
    rst_n = 1'b1; instr_valid = 1'b0; set_mask(6'b0);
    tick();
    check("reset.instr_ready", {31'h0, instr_ready}, 32'd1);
    check("reset.in_ready", {31'h0, in_ready}, 32'd0);

    // back-to-back ALU chain from the vector table
    instr_valid = 1'b1;
    for (int v = 0; v < 4; v++) begin
      set_op(vecs[v].op); imm = vecs[v].imm;
      tick();
      check("chain.acc", {24'h0, acc}, vecs[v].exp_acc);
      check("chain.c", {31'h0, flag_c}, {31'h0, vecs[v].exp_c});
      model_alu(vecs[v].op, int'(vecs[v].imm));
    end
    instr_valid = 1'b0; set_mask(6'b0);
    check("chain.retired", {16'h0, retired}, 32'd4);

    // wrap and borrow
    do_in(8'hFF, 0);
    do_alu(OP_ADD, 4'h1);
    check("wrap.acc", {24'h0, acc}, 32'h00);
    check("wrap.zc", {30'h0, flag_z, flag_c}, 32'b11);
    do_alu(OP_SUB, 4'h1);
    check("borrow.acc", {24'h0, acc}, 32'hFF);
    check("borrow.zc", {30'h0, flag_z, flag_c}, 32'b01);

    // input stall, output back-pressure
    do_in(8'hA5, 5);
    do_in(8'h3C, 1);
    do_out(3);

    // reset in WAIT_OUT drops the pending output
    set_op(OP_OUT); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; set_mask(6'b0);
    check("rst_out.pending", {31'h0, out_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    check("rst_out.valid", {31'h0, out_valid}, 32'd0);
    check("rst_out.ready", {31'h0, instr_ready}, 32'd1);
    check_state("rst_out");

    // illegal strobe combinations
    do_alu(OP_LOAD, 4'h9);
    do_illegal(6'b011000, 4'h2);
    do_illegal(6'b000000, 4'h5);

    // randomized run against the model
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 7);
      if (sel <= 3) begin
        do_alu(4'(sel), 4'($urandom_range(0, 15)));
      end else if (sel == 4) begin
        do_in(8'($urandom_range(0, 255)), $urandom_range(0, 3));
      end else if (sel == 5) begin
        do_out($urandom_range(0, 3));
      end else begin
        mask = 6'($urandom_range(0, 63));
        if ($countones(mask) == 1) mask = 6'b000000;
        do_illegal(mask, 4'($urandom_range(0, 15)));
      end
    end

    // counter wrap: retire 2^16 loads back to back from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    set_op(OP_LOAD); imm = 4'h1; instr_valid = 1'b1;
    repeat (65535) tick();
    check("wrap_cnt.max", {16'h0, retired}, 32'hFFFF);
    tick();
    instr_valid = 1'b0; set_mask(6'b0);
    check("wrap_cnt.zero", {16'h0, retired}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
